// File: rtl/note_pkg.sv
// Shared definitions for the note fetch scheduler: default sizes, the end-of-chart
// marker and the fetch FSM state encoding.
package note_pkg;

  localparam int TIME_W    = 16;
  localparam int NUM_LANES = 5;

  localparam logic [TIME_W-1:0] NOTE_END = {TIME_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/note_fetch_scheduler_rr_pick.sv
// Combinational round-robin picker: first eligible lane after last_grant,
// wrapping modulo NUM_LANES.
module note_rr_pick #(
  parameter int NUM_LANES = 5,
  parameter int IDX_W     = 3
) (
  input  logic [NUM_LANES-1:0] eligible,
  input  logic [IDX_W-1:0]     last_grant,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx
);

  int cand;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      cand = (int'(last_grant) + k) % NUM_LANES;
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/note_fetch_scheduler.sv
// Shares one note-memory read port among the lane matching units: round-robin
// grant, one read per grant, per-lane read pointers and end-of-chart tracking.
module note_fetch_scheduler
  import note_pkg::*;
#(
  parameter int  NUM_LANES  = note_pkg::NUM_LANES,
  parameter int  LANE_DEPTH = 256,
  parameter int  MEM_LAT    = 2,
  parameter int  TIME_W     = note_pkg::TIME_W,
  localparam int ADDR_W     = $clog2(NUM_LANES * LANE_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  input  logic [NUM_LANES-1:0] note_request,
  output logic [NUM_LANES-1:0] note_available,
  output logic [TIME_W-1:0]    note_time,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [TIME_W-1:0]    mem_rdata,
  output logic                 busy,
  output logic [NUM_LANES-1:0] lane_done,
  output fetch_state_t         dbg_state
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PTR_W  = $clog2(LANE_DEPTH);
  localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [TIME_W-1:0] END_MARK = {TIME_W{NOTE_END[0]}};

  fetch_state_t          state_q, state_d;
  logic [LANE_W-1:0]     grant_q, last_grant_q, pick_idx;
  logic                  pick_valid;
  logic [NUM_LANES-1:0]  eligible, done_q;
  logic [PTR_W-1:0]      ptr_q [NUM_LANES];
  logic [CNT_W-1:0]      lat_cnt_q;
  logic [TIME_W-1:0]     resp_data;

  // A lane whose pulse is on the bus this cycle may still hold its request.
  assign eligible  = note_request & ~note_available;
  assign lane_done = done_q;
  assign dbg_state = state_q;
  // Memory data is sampled in RESP, the cycle it becomes valid; done lanes never read.
  assign resp_data = done_q[grant_q] ? END_MARK : mem_rdata;

  note_rr_pick #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (LANE_W)
  ) u_pick (
    .eligible    (eligible),
    .last_grant  (last_grant_q),
    .grant_valid (pick_valid),
    .grant_idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_valid) state_d = done_q[pick_idx] ? RESP : WAIT;
      WAIT: if (lat_cnt_q == CNT_W'(MEM_LAT - 1)) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state_q        <= IDLE;
      done_q         <= '0;
      note_available <= '0;
      mem_rd_en      <= 1'b0;
      busy           <= 1'b0;
      lat_cnt_q      <= '0;
      for (int i = 0; i < NUM_LANES; i++) ptr_q[i] <= '0;
      if (reset) begin
        last_grant_q <= LANE_W'(NUM_LANES - 1);
        grant_q      <= '0;
        note_time    <= '0;
        mem_addr     <= '0;
      end
    end else begin
      state_q        <= state_d;
      mem_rd_en      <= 1'b0;
      note_available <= '0;
      busy           <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q      <= pick_idx;
            last_grant_q <= pick_idx;
            lat_cnt_q    <= '0;
            mem_addr     <= ADDR_W'({pick_idx, ptr_q[pick_idx]});
            mem_rd_en    <= !done_q[pick_idx];
          end
        end
        WAIT: lat_cnt_q <= lat_cnt_q + 1'b1;
        RESP: begin
          note_available <= NUM_LANES'(1) << grant_q;
          note_time      <= resp_data;
          if (resp_data == END_MARK) begin
            done_q[grant_q] <= 1'b1;
          end else if (&ptr_q[grant_q]) begin
            done_q[grant_q] <= 1'b1;
          end else begin
            ptr_q[grant_q] <= ptr_q[grant_q] + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_fetch_scheduler.sv
// Directed bench for note_fetch_scheduler with a MEM_LAT-deep note memory model.
module tb_note_fetch_scheduler;
  import note_pkg::*;

  localparam int NL = 5;
  localparam int LD = 256;
  localparam int ML = 2;
  localparam int TW = 16;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          restart = 1'b0;
  logic [NL-1:0] note_request = '0;
  logic [NL-1:0] note_available;
  logic [TW-1:0] note_time;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [TW-1:0] mem_rdata;
  logic          busy;
  logic [NL-1:0] lane_done;
  fetch_state_t  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  // clock / reset block
  always #5 clk = ~clk;

  note_fetch_scheduler #(
    .NUM_LANES (NL), .LANE_DEPTH (LD), .MEM_LAT (ML), .TIME_W (TW)
  ) dut (
    .clk (clk), .reset (reset), .restart (restart),
    .note_request (note_request), .note_available (note_available),
    .note_time (note_time), .mem_rd_en (mem_rd_en), .mem_addr (mem_addr),
    .mem_rdata (mem_rdata), .busy (busy), .lane_done (lane_done),
    .dbg_state (dbg_state)
  );

  // note memory: contents are addr + 0x100 unless overridden
  logic [TW-1:0] mem [0:(1<<AW)-1];
  logic [TW-1:0] pipe [ML];
  always @(posedge clk) begin
    pipe[0] <= mem_rd_en ? mem[mem_addr] : 16'hBAD0;
    for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[ML-1];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; restart = 1'b0; note_request = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver: raise one lane's request at this negedge, hold it one cycle past its pulse.
  task automatic fetch(input int lane, output logic [TW-1:0] t_out, output int lat,
                       output int rd_at, output logic [AW-1:0] addr_seen,
                       output logic [NL-1:0] avail_seen);
    t_out = '0; lat = -1; rd_at = -1; addr_seen = '0; avail_seen = '0;
    note_request[lane] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_rd_en && rd_at < 0) begin rd_at = k; addr_seen = mem_addr; end
      if (note_available[lane]) begin
        t_out = note_time; lat = k; avail_seen = note_available;
        break;
      end
    end
    @(negedge clk);
    note_request[lane] = 1'b0;
  endtask

  task automatic test_reset();
    note_request = 5'b10101;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (note_available !== 5'b0) begin miscompares++; $display("FAIL rst_avail: got %b want 0", note_available); end
    vectors++; if (note_time !== 16'h0) begin miscompares++; $display("FAIL rst_time: got %h want 0", note_time); end
    vectors++; if (mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL rst_rd_en: got %b want 0", mem_rd_en); end
    vectors++; if (mem_addr !== 11'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (lane_done !== 5'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", lane_done); end
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want IDLE", dbg_state); end
    note_request = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [TW-1:0] t; int lat, rd; logic [AW-1:0] a; logic [NL-1:0] av;
    do_reset();
    fetch(2, t, lat, rd, a, av);
    vectors++; if (rd !== 1 || a !== 11'h200) begin miscompares++; $display("FAIL single_rd: got cyc %0d addr %h want cyc 1 addr 200", rd, a); end
    vectors++; if (lat !== 4 || t !== 16'd150) begin miscompares++; $display("FAIL single_resp: got cyc %0d time %0d want cyc 4 time 150", lat, t); end
    vectors++; if (av !== 5'b00100) begin miscompares++; $display("FAIL single_onehot: got %b want 00100", av); end
    vectors++; if (mem_rd_en !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_noregrant: got rd_en %b busy %b want 0 0", mem_rd_en, busy); end
    fetch(2, t, lat, rd, a, av);
    vectors++; if (a !== 11'h201 || t !== 16'h0301) begin miscompares++; $display("FAIL single_ptr: got addr %h time %h want 201 0301", a, t); end
  endtask

  task automatic test_contention();
    int n; int got_lane [4]; int got_k [4]; logic [TW-1:0] got_t [4];
    int exp_lane [4]; int exp_k [4]; logic [TW-1:0] exp_t [4];
    logic [NL-1:0] drop_mask;
    exp_lane = '{0, 1, 4, 0};
    exp_k    = '{4, 8, 12, 16};
    exp_t    = '{16'h0100, 16'h0200, 16'h0500, 16'h0101};
    do_reset();
    n = 0; drop_mask = '0;
    note_request = 5'b10011;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      note_request = note_request & ~drop_mask;
      drop_mask = note_available;
      if (k == 9) note_request[0] = 1'b1;
      if (note_available != '0 && n < 4) begin
        got_lane[n] = $clog2(note_available); got_k[n] = k; got_t[n] = note_time;
        n++;
      end
    end
    note_request = '0;
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL cont_count: got %0d pulses want 4", n); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (i >= n || got_lane[i] !== exp_lane[i] || got_k[i] !== exp_k[i] || got_t[i] !== exp_t[i]) begin
        miscompares++;
        $display("FAIL cont_grant%0d: got lane %0d cyc %0d time %h want lane %0d cyc %0d time %h",
                 i, got_lane[i], got_k[i], got_t[i], exp_lane[i], exp_k[i], exp_t[i]);
      end
    end
  endtask

  task automatic test_end_marker();
    logic [TW-1:0] t; int lat, rd; logic [AW-1:0] a; logic [NL-1:0] av;
    do_reset();
    fetch(3, t, lat, rd, a, av);
    vectors++; if (t !== 16'd80 || lane_done[3] !== 1'b0) begin miscompares++; $display("FAIL end_first: got time %0d done %b want 80 0", t, lane_done[3]); end
    fetch(3, t, lat, rd, a, av);
    vectors++; if (t !== 16'hFFFF || a !== 11'h301 || lane_done !== 5'b01000) begin miscompares++; $display("FAIL end_marker: got time %h addr %h done %b want FFFF 301 01000", t, a, lane_done); end
    fetch(3, t, lat, rd, a, av);
    vectors++; if (t !== 16'hFFFF || lat !== 2 || rd !== -1) begin miscompares++; $display("FAIL end_doneserve: got time %h cyc %0d rd %0d want FFFF 2 -1", t, lat, rd); end
  endtask

  task automatic test_saturation();
    logic [TW-1:0] t; int lat, rd; logic [AW-1:0] a; logic [NL-1:0] av;
    int bad; logic [TW-1:0] exp_t;
    do_reset();
    bad = 0;
    for (int i = 0; i < LD; i++) begin
      fetch(1, t, lat, rd, a, av);
      exp_t = 16'h0200 + 16'(i);
      if (t !== exp_t || lat !== 4) begin
        if (bad == 0) $display("FAIL sat_data: fetch %0d got time %h cyc %0d want %h 4", i, t, lat, exp_t);
        bad++;
      end
      if (i == LD - 2) begin
        vectors++; if (lane_done[1] !== 1'b0) begin miscompares++; $display("FAIL sat_early: got done %b want 0", lane_done[1]); end
      end
    end
    vectors++; if (bad != 0) miscompares++;
    vectors++; if (lane_done[1] !== 1'b1) begin miscompares++; $display("FAIL sat_done: got %b want 1", lane_done[1]); end
    fetch(1, t, lat, rd, a, av);
    vectors++; if (t !== 16'hFFFF || lat !== 2 || rd !== -1) begin miscompares++; $display("FAIL sat_after: got time %h cyc %0d rd %0d want FFFF 2 -1", t, lat, rd); end
  endtask

  task automatic test_restart();
    logic [TW-1:0] t; int lat, rd; logic [AW-1:0] a; logic [NL-1:0] av;
    int pulse_k, rd_k; logic [AW-1:0] rd_a; logic [TW-1:0] pt;
    do_reset();
    fetch(3, t, lat, rd, a, av);
    fetch(3, t, lat, rd, a, av);
    fetch(4, t, lat, rd, a, av);
    note_request[4] = 1'b1;
    @(negedge clk);
    vectors++; if (mem_rd_en !== 1'b1 || mem_addr !== 11'h401) begin miscompares++; $display("FAIL rs_inflight: got rd %b addr %h want 1 401", mem_rd_en, mem_addr); end
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    vectors++; if (busy !== 1'b0 || note_available !== 5'b0 || lane_done !== 5'b0) begin miscompares++; $display("FAIL rs_clear: got busy %b avail %b done %b want 0 0 0", busy, note_available, lane_done); end
    pulse_k = -1; rd_k = -1; rd_a = '0; pt = '0;
    for (int k = 4; k <= 14; k++) begin
      @(negedge clk);
      if (mem_rd_en && rd_k < 0) begin rd_k = k; rd_a = mem_addr; end
      if (note_available != '0) begin pulse_k = k; pt = note_time; break; end
    end
    @(negedge clk);
    note_request = '0;
    vectors++; if (rd_k !== 4 || rd_a !== 11'h400) begin miscompares++; $display("FAIL rs_reread: got cyc %0d addr %h want 4 400", rd_k, rd_a); end
    vectors++; if (pulse_k !== 7 || pt !== 16'h0500) begin miscompares++; $display("FAIL rs_resp: got cyc %0d time %h want 7 0500", pulse_k, pt); end
  endtask

  task automatic test_reset_in_resp();
    logic [TW-1:0] t; int lat, rd; logic [AW-1:0] a; logic [NL-1:0] av;
    do_reset();
    fetch(3, t, lat, rd, a, av);
    fetch(3, t, lat, rd, a, av);
    fetch(2, t, lat, rd, a, av);
    note_request[2] = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (note_available !== 5'b0 || note_time !== 16'h0 || mem_rd_en !== 1'b0) begin miscompares++; $display("FAIL rr_outs: got avail %b time %h rd %b want 0 0 0", note_available, note_time, mem_rd_en); end
    vectors++; if (mem_addr !== 11'h0 || busy !== 1'b0 || lane_done !== 5'b0) begin miscompares++; $display("FAIL rr_state: got addr %h busy %b done %b want 0 0 0", mem_addr, busy, lane_done); end
    reset = 1'b0;
    note_request = '0;
    @(negedge clk);
    fetch(2, t, lat, rd, a, av);
    vectors++; if (a !== 11'h200 || t !== 16'd150) begin miscompares++; $display("FAIL rr_ptr: got addr %h time %0d want 200 150", a, t); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'(i) + 16'h0100;
    mem[11'h200] = 16'd150;
    mem[11'h300] = 16'd80;
    mem[11'h301] = 16'hFFFF;
    for (int i = 0; i < ML; i++) pipe[i] = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_end_marker();
    test_saturation();
    test_restart();
    test_reset_in_resp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
